mem_write_checker: RTL and testbench
====================================

# mem_write_checker

Parametrised self-checking monitor for the CPU testbenches. It holds a preloaded table of expected data-memory writes (address, data) and watches the CPU's memwrite/dataaddr/writedata/pc bus. Each observed write is compared, in order, against the table. A run ends in PASS or FAIL, with the failing entry index, the failing pc, the error cause and the elapsed cycle count latched for reporting. It replaces hand-timed single-point checks that sample at a fixed simulation time.

## Interface
- WIDTH, 32, data/address/pc width
- DEPTH, 8, max expected-write entries (power of two, ≥2)
- TIMEOUT, 1024, max cycles in RUN before timeout failure (≥1)
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all state including table
- exp_push  in  1  load one expected entry (accepted only in IDLE)
- exp_addr  in  WIDTH  expected address for pushed entry
- exp_data  in  WIDTH  expected data for pushed entry
- start  in  1  arm checker (accepted only in IDLE)
- memwrite  in  1  CPU memory write strobe
- dataaddr  in  WIDTH  CPU write address
- writedata  in  WIDTH  CPU write data
- pc  in  WIDTH  CPU program counter
- busy  out  1  high in RUN
- done  out  1  high in PASS or FAIL
- pass  out  1  high in PASS
- fail  out  1  high in FAIL
- err_code  out  2  0 none, 1 address mismatch, 2 data mismatch, 3 timeout
- err_index  out  $clog2(DEPTH)  table index of failing or next-expected entry
- fail_pc  out  WIDTH  pc sampled on the failing cycle
- cycles  out  $clog2(TIMEOUT+1)  cycles spent in RUN, saturating at TIMEOUT
- loaded  out  $clog2(DEPTH+1)  number of entries in table
- overflow  out  1  sticky; a push was attempted with table full

## Operation
- States: IDLE, RUN, PASS, FAIL.
- Reset: state IDLE, all outputs 0, table count 0, overflow 0.
- IDLE:
  - exp_push with loaded<DEPTH writes entry[loaded] and increments loaded.
  - exp_push with loaded==DEPTH drops the entry and sets overflow.
  - start with loaded>0 → RUN; index←0, cycles←0.
  - start with loaded==0 → PASS directly.
  - start and exp_push in the same cycle: the push is taken first, then start with the updated count. A table containing only the pushed entry is valid.
- RUN, evaluated every cycle:
  - memwrite=1, dataaddr≠entry[index].addr → FAIL, err_code=1.
  - memwrite=1, address matches, writedata≠entry[index].data → FAIL, err_code=2. Address mismatch has priority over data mismatch.
  - memwrite=1, full match: if index==loaded-1 → PASS, otherwise index+1.
  - memwrite=0: no comparison.
  - cycles increments each RUN cycle. On the cycle where cycles==TIMEOUT-1 without a final match → FAIL, err_code=3.
  - A final match on the timeout cycle → PASS; match has priority.
- On FAIL: err_index holds the offending index and fail_pc holds pc from the failing cycle. On timeout, fail_pc is the pc on the timeout cycle.
- PASS/FAIL are terminal until reset. Pushes and start are ignored there. Writes after PASS are not checked.
- exp_push during RUN is ignored and does not set overflow.

## Timing
- Single-cycle compare: the write sampled at edge N is reflected in state/outputs after edge N, i.e. visible in cycle N+1.
- start sampled at edge N → busy=1 from cycle N+1. cycles=0 in the first RUN cycle.
- done/pass/fail are registered, mutually consistent, and stable until reset.
- Reset mid-RUN: at the next edge all outputs return to reset values and the table is emptied.
- cycles saturates; it never wraps.

## Test plan
- Single entry: push (1,1), start, CPU writes addr 1 data 1 on RUN cycle 3 → pass=1 next cycle, cycles=4, err_code=0.
- Ordered sequence: push (0x54,7),(0x50,0xC),(0x54,0xFFFFFFFF); matching writes on cycles 2,5,9 → pass after the third write, err_index=2.
- Data mismatch: push (0x10,5); write addr 0x10 data 6 with pc=0x0000_0030 → fail, err_code=2, err_index=0, fail_pc=0x30. A second wrong-address write in another run → err_code=1.
- Timeout: TIMEOUT=16, push one entry, never assert memwrite → fail after exactly 16 RUN cycles, err_code=3, cycles=16. Matching write on cycle 15 (last) → pass instead.
- Table bounds: DEPTH=8, push 9 entries → loaded=8, overflow=1. Start with 0 entries → pass immediately. Push and start in the same cycle → loaded=1, busy=1.
- Reset mid-run: two of three entries matched, assert reset one cycle → busy=0, loaded=0, done=0, cycles=0; a later start with an empty table → pass.

Source files
------------

// File: rtl/mem_write_checker_if.sv
// Bus bundle between the CPU-side driver and mem_write_checker: table load,
// start, observed CPU write bus and the latched verdict.
interface mem_write_checker_if #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 1024
);
  logic                         exp_push;
  logic [WIDTH-1:0]             exp_addr;
  logic [WIDTH-1:0]             exp_data;
  logic                         start;
  logic                         memwrite;
  logic [WIDTH-1:0]             dataaddr;
  logic [WIDTH-1:0]             writedata;
  logic [WIDTH-1:0]             pc;
  logic                         busy;
  logic                         done;
  logic                         pass;
  logic                         fail;
  logic [1:0]                   err_code;
  logic [$clog2(DEPTH)-1:0]     err_index;
  logic [WIDTH-1:0]             fail_pc;
  logic [$clog2(TIMEOUT+1)-1:0] cycles;
  logic [$clog2(DEPTH+1)-1:0]   loaded;
  logic                         overflow;

  modport master (
    output exp_push, exp_addr, exp_data, start,
    output memwrite, dataaddr, writedata, pc,
    input  busy, done, pass, fail, err_code, err_index,
    input  fail_pc, cycles, loaded, overflow
  );

  modport slave (
    input  exp_push, exp_addr, exp_data, start,
    input  memwrite, dataaddr, writedata, pc,
    output busy, done, pass, fail, err_code, err_index,
    output fail_pc, cycles, loaded, overflow
  );
endinterface

// File: rtl/mem_write_checker.sv
// Ordered data-memory write checker: compares each CPU write against a
// preloaded table and latches PASS/FAIL with cause, index, pc and cycle count.
module mem_write_checker #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 1024
) (
  input logic              clk,
  input logic              reset,
  mem_write_checker_if.slave bus
);
  localparam int IW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} state_t;

  state_t           state;
  logic [WIDTH-1:0] tab_addr [DEPTH];
  logic [WIDTH-1:0] tab_data [DEPTH];
  logic [IW-1:0]    index;
  logic [LW-1:0]    count;
  logic [CW-1:0]    cyc;
  logic             busy_q, done_q, pass_q, fail_q, overflow_q;
  logic [1:0]       err_q;
  logic [WIDTH-1:0] fail_pc_q;

  logic             push_ok;
  logic [LW-1:0]    count_next;
  logic [WIDTH-1:0] cur_addr, cur_data;
  logic             last_entry, timeout_cyc;

  always_comb begin
    push_ok     = bus.exp_push && (count < LW'(DEPTH));
    count_next  = count + LW'(push_ok);
    cur_addr    = tab_addr[index];
    cur_data    = tab_data[index];
    last_entry  = (LW'(index) == count - LW'(1));
    timeout_cyc = (cyc == CW'(TIMEOUT - 1));
  end

  // A push and a start in the same cycle see the post-push count.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      index      <= '0;
      count      <= '0;
      cyc        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      overflow_q <= 1'b0;
      err_q      <= 2'd0;
      fail_pc_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tab_addr[i] <= '0;
        tab_data[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (push_ok) begin
            tab_addr[count[IW-1:0]] <= bus.exp_addr;
            tab_data[count[IW-1:0]] <= bus.exp_data;
            count                   <= count_next;
          end
          if (bus.exp_push && !push_ok) overflow_q <= 1'b1;
          if (bus.start) begin
            if (count_next != '0) begin
              state  <= RUN;
              busy_q <= 1'b1;
              index  <= '0;
              cyc    <= '0;
            end else begin
              state  <= PASS;
              pass_q <= 1'b1;
              done_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (cyc != CW'(TIMEOUT)) cyc <= cyc + CW'(1);
          // Address mismatch outranks data mismatch; a final match outranks timeout.
          if (bus.memwrite && bus.dataaddr != cur_addr) begin
            state <= FAIL; busy_q <= 1'b0; fail_q <= 1'b1; done_q <= 1'b1;
            err_q <= 2'd1; fail_pc_q <= bus.pc;
          end else if (bus.memwrite && bus.writedata != cur_data) begin
            state <= FAIL; busy_q <= 1'b0; fail_q <= 1'b1; done_q <= 1'b1;
            err_q <= 2'd2; fail_pc_q <= bus.pc;
          end else if (bus.memwrite && last_entry) begin
            state <= PASS; busy_q <= 1'b0; pass_q <= 1'b1; done_q <= 1'b1;
          end else begin
            if (bus.memwrite) index <= index + IW'(1);
            if (timeout_cyc) begin
              state <= FAIL; busy_q <= 1'b0; fail_q <= 1'b1; done_q <= 1'b1;
              err_q <= 2'd3; fail_pc_q <= bus.pc;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.fail      = fail_q;
  assign bus.err_code  = err_q;
  assign bus.err_index = index;
  assign bus.fail_pc   = fail_pc_q;
  assign bus.cycles    = cyc;
  assign bus.loaded    = count;
  assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_mem_write_checker.sv
// Self-checking bench for mem_write_checker: directed cases plus randomized
// runs scored against a sequential reference model of the write-checking rules.
module tb_mem_write_checker;
  localparam int WIDTH   = 32;
  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checkCount = 0;
  int   passCount  = 0;

  mem_write_checker_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) bus ();

  mem_write_checker #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Scenario description: expected table and per-RUN-cycle CPU bus activity.
  int          nExp;
  logic [31:0] eAddr [DEPTH];
  logic [31:0] eData [DEPTH];
  logic        mw  [TIMEOUT];
  logic [31:0] wa  [TIMEOUT];
  logic [31:0] wd  [TIMEOUT];
  logic [31:0] wpc [TIMEOUT];

  // Model results.
  logic        mPass, mFail;
  logic [1:0]  mCode;
  int          mIndex, mCycles, mEndK;
  logic [31:0] mPc;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearBus();
    bus.exp_push = 1'b0; bus.exp_addr = '0; bus.exp_data = '0; bus.start = 1'b0;
    bus.memwrite = 1'b0; bus.dataaddr = '0; bus.writedata = '0; bus.pc = '0;
  endtask

  task automatic applyStimulus(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [31:0] p);
    bus.memwrite = w; bus.dataaddr = a; bus.writedata = d; bus.pc = p;
    tick();
  endtask

  task automatic doReset();
    clearBus();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic pushEntry(input logic [31:0] a, input logic [31:0] d);
    bus.exp_push = 1'b1; bus.exp_addr = a; bus.exp_data = d;
    tick();
    bus.exp_push = 1'b0;
  endtask

  task automatic clearStim();
    for (int k = 0; k < TIMEOUT; k++) begin
      mw[k] = 1'b0; wa[k] = 32'h0; wd[k] = 32'h0; wpc[k] = 32'h100 + 32'(4 * k);
    end
  endtask

  // Walk the RUN cycles in order: each write must equal the next table entry.
  task automatic modelRun();
    int  m;
    bit  fin;
    m = 0; fin = 0;
    mPass = 0; mFail = 0; mCode = 0; mIndex = 0; mCycles = 0; mPc = 0; mEndK = -1;
    for (int k = 0; k < TIMEOUT && !fin; k++) begin
      if (mw[k]) begin
        if (wa[k] != eAddr[m]) begin
          mFail = 1; mCode = 1; mIndex = m; mPc = wpc[k]; fin = 1;
        end else if (wd[k] != eData[m]) begin
          mFail = 1; mCode = 2; mIndex = m; mPc = wpc[k]; fin = 1;
        end else begin
          m++;
          if (m == nExp) begin
            mPass = 1; mIndex = nExp - 1; fin = 1;
          end
        end
      end
      if (!fin && k == TIMEOUT - 1) begin
        mFail = 1; mCode = 3; mIndex = m; mPc = wpc[k]; fin = 1;
      end
      if (fin) begin
        mCycles = k + 1; mEndK = k;
      end
    end
  endtask

  task automatic runScenario(input string tag, input bit noisy);
    modelRun();
    doReset();
    for (int i = 0; i < nExp; i++) pushEntry(eAddr[i], eData[i]);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    checkOutput({tag, ".busy0"}, bus.busy, 1'b1);
    checkOutput({tag, ".cyc0"}, bus.cycles, 0);
    for (int k = 0; k < TIMEOUT; k++) begin
      if (noisy) begin
        bus.exp_push = 1'($urandom_range(0, 1));
        bus.exp_addr = $urandom; bus.exp_data = $urandom;
        bus.start    = 1'($urandom_range(0, 1));
      end
      applyStimulus(mw[k], wa[k], wd[k], wpc[k]);
      checkOutput({tag, ".done_k"}, bus.done, (mEndK >= 0 && k >= mEndK));
    end
    clearBus();
    applyStimulus(1'b1, 32'hDEAD_0000, 32'hBEEF, 32'h999);
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0);
    checkOutput({tag, ".pass"}, bus.pass, mPass);
    checkOutput({tag, ".fail"}, bus.fail, mFail);
    checkOutput({tag, ".done"}, bus.done, 1'b1);
    checkOutput({tag, ".busy"}, bus.busy, 1'b0);
    checkOutput({tag, ".err_code"}, bus.err_code, mCode);
    checkOutput({tag, ".err_index"}, bus.err_index, mIndex);
    checkOutput({tag, ".fail_pc"}, bus.fail_pc, mPc);
    checkOutput({tag, ".cycles"}, bus.cycles, mCycles);
    checkOutput({tag, ".loaded"}, bus.loaded, nExp);
    checkOutput({tag, ".overflow"}, bus.overflow, 1'b0);
  endtask

  task automatic randomScenario(input int id);
    int g, r;
    nExp = $urandom_range(1, DEPTH);
    for (int i = 0; i < nExp; i++) begin
      eAddr[i] = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
      eData[i] = $urandom;
    end
    clearStim();
    g = 0;
    for (int k = 0; k < TIMEOUT; k++) begin
      wa[k] = $urandom; wd[k] = $urandom; wpc[k] = $urandom;
      if ($urandom_range(0, 99) < 40) begin
        mw[k] = 1'b1;
        if (g < nExp) begin
          r = $urandom_range(0, 99);
          wa[k] = eAddr[g]; wd[k] = eData[g];
          if (r < 8) wa[k] = eAddr[g] ^ 32'h4;
          else if (r < 16) wd[k] = eData[g] ^ (32'h1 << $urandom_range(0, 31));
          else g++;
        end
      end
    end
    runScenario($sformatf("rand%0d", id), 1'b1);
  endtask

  initial begin
    clearBus();
    doReset();
    checkOutput("rst.busy", bus.busy, 1'b0);
    checkOutput("rst.done", bus.done, 1'b0);
    checkOutput("rst.pass", bus.pass, 1'b0);
    checkOutput("rst.fail", bus.fail, 1'b0);
    checkOutput("rst.err_code", bus.err_code, 0);
    checkOutput("rst.err_index", bus.err_index, 0);
    checkOutput("rst.fail_pc", bus.fail_pc, 0);
    checkOutput("rst.cycles", bus.cycles, 0);
    checkOutput("rst.loaded", bus.loaded, 0);
    checkOutput("rst.overflow", bus.overflow, 1'b0);

    nExp = 1; eAddr[0] = 32'h1; eData[0] = 32'h1;
    clearStim();
    mw[3] = 1'b1; wa[3] = 32'h1; wd[3] = 32'h1;
    runScenario("single", 1'b0);
    checkOutput("single.cyc_exact", bus.cycles, 4);

    nExp = 3;
    eAddr[0] = 32'h54; eData[0] = 32'h7;
    eAddr[1] = 32'h50; eData[1] = 32'hC;
    eAddr[2] = 32'h54; eData[2] = 32'hFFFF_FFFF;
    clearStim();
    mw[2] = 1'b1; wa[2] = 32'h54; wd[2] = 32'h7;
    mw[5] = 1'b1; wa[5] = 32'h50; wd[5] = 32'hC;
    mw[9] = 1'b1; wa[9] = 32'h54; wd[9] = 32'hFFFF_FFFF;
    runScenario("ordered", 1'b0);
    checkOutput("ordered.idx2", bus.err_index, 2);

    nExp = 1; eAddr[0] = 32'h10; eData[0] = 32'h5;
    clearStim();
    mw[0] = 1'b1; wa[0] = 32'h10; wd[0] = 32'h6; wpc[0] = 32'h30;
    runScenario("datamis", 1'b0);
    checkOutput("datamis.code2", bus.err_code, 2);
    clearStim();
    mw[1] = 1'b1; wa[1] = 32'h14; wd[1] = 32'h6; wpc[1] = 32'h44;
    runScenario("addrmis", 1'b0);
    checkOutput("addrmis.code1", bus.err_code, 1);

    clearStim();
    runScenario("timeout", 1'b0);
    checkOutput("timeout.cyc16", bus.cycles, 16);
    clearStim();
    mw[TIMEOUT-1] = 1'b1; wa[TIMEOUT-1] = 32'h10; wd[TIMEOUT-1] = 32'h5;
    runScenario("lastcyc", 1'b0);
    checkOutput("lastcyc.pass", bus.pass, 1'b1);

    doReset();
    for (int i = 0; i < DEPTH + 1; i++) pushEntry(32'(4 * i), 32'(i));
    checkOutput("ovf.loaded", bus.loaded, DEPTH);
    checkOutput("ovf.flag", bus.overflow, 1'b1);
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    checkOutput("ovf.busy", bus.busy, 1'b1);

    doReset();
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    checkOutput("empty.pass", bus.pass, 1'b1);
    checkOutput("empty.done", bus.done, 1'b1);
    checkOutput("empty.busy", bus.busy, 1'b0);

    doReset();
    bus.exp_push = 1'b1; bus.exp_addr = 32'h8; bus.exp_data = 32'h9; bus.start = 1'b1;
    tick();
    clearBus();
    checkOutput("pushstart.loaded", bus.loaded, 1);
    checkOutput("pushstart.busy", bus.busy, 1'b1);
    applyStimulus(1'b1, 32'h8, 32'h9, 32'h0);
    checkOutput("pushstart.pass", bus.pass, 1'b1);

    doReset();
    pushEntry(32'h20, 32'h1); pushEntry(32'h24, 32'h2); pushEntry(32'h28, 32'h3);
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    applyStimulus(1'b1, 32'h20, 32'h1, 32'h0);
    applyStimulus(1'b1, 32'h24, 32'h2, 32'h4);
    clearBus();
    reset = 1'b1; tick(); reset = 1'b0;
    checkOutput("midrst.busy", bus.busy, 1'b0);
    checkOutput("midrst.loaded", bus.loaded, 0);
    checkOutput("midrst.done", bus.done, 1'b0);
    checkOutput("midrst.cycles", bus.cycles, 0);
    checkOutput("midrst.err_index", bus.err_index, 0);
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    checkOutput("midrst.pass", bus.pass, 1'b1);

    for (int s = 0; s < 24; s++) randomScenario(s);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
